sram_like_slave_mem: RTL

//  - Responder (slave) end of the sram-like bus: accepts req/addr_ok handshakes, backs them with on-chip memory, returns data_ok/rdata.
//  - One instance per port (inst, data). Stands in for the memory system behind the CPU in unit/SoC simulation.
//  - Supports multiple outstanding requests, retired strictly in order after a configurable latency.

---
 rtl/sram_like_pkg.sv | 16 +
 rtl/sram_like_resp_fifo.sv | 58 +++++
 rtl/sram_like_slave_mem.sv | 92 +++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared types and constants for the sram-like bus responder memory.
package sram_like_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Wide enough for LATENCY-1 plus the optional random extra delay of up to 3.
   localparam int TIMER_W = 8;

   typedef struct packed {
      logic [31:0]        rdata;
      logic [TIMER_W-1:0] timer;
   } resp_entry_t;

endpackage

// File: rtl/sram_like_resp_fifo.sv
// In-order response queue: DEPTH circular entries, each with a countdown timer
// that saturates at zero; only the head may retire.
module sram_like_resp_fifo
   import sram_like_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  resp_entry_t              push_entry,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     head_ready,
   output logic [31:0]              head_rdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   resp_entry_t        entries [DEPTH];
   logic [DEPTH-1:0]   valid;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // The caller never pushes into a full queue, so push and pop never target the same slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].timer != '0))
               entries[i].timer <= entries[i].timer - 1'b1;
         end
         if (push) begin
            entries[wr_ptr] <= push_entry;
            valid[wr_ptr]   <= 1'b1;
            wr_ptr          <= next_ptr(wr_ptr);
         end
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= next_ptr(rd_ptr);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head_ready = valid[rd_ptr] && (entries[rd_ptr].timer == '0);
   assign head_rdata = entries[rd_ptr].rdata;

endmodule

// File: rtl/sram_like_slave_mem.sv
// Responder end of the sram-like bus backed by on-chip memory, with in-order delayed responses.
// Optional macro SRAM_LIKE_RAND_DELAY_EN adds LFSR-driven accept gating and extra latency.
module sram_like_slave_mem
   import sram_like_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 2,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  count;
   logic              accept;
   logic              head_ready;
   logic [31:0]       head_rdata;
   logic              rand_gate;
   logic [1:0]        extra_delay;
   resp_entry_t       push_entry;
   logic              unused_bits;

   assign idx         = addr[ADDR_W+1:2];
   assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_LIKE_RAND_DELAY_EN
   logic [15:0] lfsr;

   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   end

   assign rand_gate   = lfsr[0];
   assign extra_delay = lfsr[2:1];
`else
   assign rand_gate   = 1'b1;
   assign extra_delay = 2'd0;
`endif

   // A same-cycle retire does not free a slot for the incoming request.
   assign addr_ok = req && !reset && rand_gate && (count < CNT_W'(DEPTH));
   assign accept  = req && addr_ok;

   always_comb begin
      push_entry.rdata = wr ? 32'd0 : mem[idx];
      push_entry.timer = TIMER_W'(LATENCY - 1) + TIMER_W'(extra_delay);
   end

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b])
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   sram_like_resp_fifo #(
      .DEPTH (DEPTH)
   ) u_resp_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (accept),
      .push_entry (push_entry),
      .pop        (data_ok),
      .count      (count),
      .head_ready (head_ready),
      .head_rdata (head_rdata)
   );

   assign data_ok = head_ready && !reset;
   assign rdata   = data_ok ? head_rdata : 32'd0;

endmodule
